// File: rtl/mult_nn_pkg.sv
// -----------------------------------------------------------------------------
// mult_nn_pkg
// Shared definitions for the multiplier / dot-product datapath.
//   MULT_N    : default multiplier operand width (products are 2*MULT_N bits)
//   DOT_LEN   : default maximum number of products per dot product
//   acc_width : accumulator width = product width + guard bits for LEN terms
//   cnt_width : width of a beat counter able to hold the value LEN
//   state_t   : control states of the dot-product accumulator
// -----------------------------------------------------------------------------
package mult_nn_pkg;

    localparam int MULT_N  = 16;
    localparam int DOT_LEN = 16;

    // Summing LEN values of 2*n bits needs at most clog2(LEN) extra bits,
    // so the accumulator can never wrap.
    function automatic int acc_width(input int n_w, input int len);
        return 2 * n_w + $clog2(len);
    endfunction

    // The counter must represent LEN itself, hence LEN+1 distinct values.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

    localparam int ACC_W = acc_width(MULT_N, DOT_LEN);
    localparam int CNT_W = cnt_width(DOT_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : mult_nn_pkg

// File: rtl/dot_accum.sv
// -----------------------------------------------------------------------------
// dot_accum
// Accumulates a stream of unsigned products into a dot product of up to LEN
// terms and presents the result with a valid/ready handshake.
//
// Parameters
//   n     : multiplier operand width, products are 2*n bits
//   LEN   : maximum number of products per dot product (LEN >= 1)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : product beat present
//   in_ready   : block accepts a beat this cycle
//   in_prod    : unsigned product (2*n bits)
//   in_last    : final beat of a vector shorter than LEN
//   out_valid  : completed dot product available
//   out_ready  : consumer takes the result
//   out_sum    : unsigned sum of the vector's products (ACC_W bits)
//   out_count  : number of beats summed into out_sum (CNT_W bits)
//
// Behaviour summary
//   IDLE  : ready for the first beat of a vector.
//   ACCUM : adding further beats until LEN beats or an in_last beat.
//   HOLD  : result presented and held stable; input readiness follows
//           out_ready so a new vector can start on the same cycle the
//           result is taken, keeping the stream gap-free.
// -----------------------------------------------------------------------------
module dot_accum
    import mult_nn_pkg::*;
#(
    parameter int  n     = MULT_N,
    parameter int  LEN   = DOT_LEN,
    localparam int ACC_W = acc_width(n, LEN),
    localparam int CNT_W = cnt_width(LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*n-1:0]     in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_count
);

    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(LEN);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    // With LEN==1 every vector is complete after its first beat.
    localparam bit               SINGLE  = (LEN == 1);

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg,   acc_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;

    logic [ACC_W-1:0]   prod_ext;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;

    assign prod_ext = ACC_W'(in_prod);
    assign cnt_inc  = cnt_reg + ONE_CNT;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    acc_next   = prod_ext;
                    cnt_next   = ONE_CNT;
                    state_next = (in_last || SINGLE) ? HOLD : ACCUM;
                end
            end

            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    acc_next = acc_reg + prod_ext;
                    cnt_next = cnt_inc;
                    // Reaching LEN closes the vector whether or not in_last
                    // is set, so a redundant in_last on that beat is harmless.
                    if ((cnt_inc == LEN_CNT) || in_last) begin
                        state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                out_valid = 1'b1;
                // A beat can only be taken when the held result leaves this
                // cycle; otherwise the new beat would overwrite it.
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (out_ready) begin
                    if (accept) begin
                        acc_next   = prod_ext;
                        cnt_next   = ONE_CNT;
                        state_next = (in_last || SINGLE) ? HOLD : ACCUM;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The accumulator only changes on an accept, so while in HOLD these stay
    // stable until the result is consumed.
    assign out_sum   = acc_reg;
    assign out_count = cnt_reg;

endmodule : dot_accum

// File: tb/tb_dot_accum.sv
module tb_dot_accum;
    import mult_nn_pkg::*;

    localparam int TN    = 16;
    localparam int TLEN  = 4;
    localparam int TACC  = 2 * TN + $clog2(TLEN);
    localparam int TCNT  = $clog2(TLEN + 1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2*TN-1:0]   in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [TACC-1:0]   out_sum;
    logic [TCNT-1:0]   out_count;

    typedef struct {
        logic [63:0] sum;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    dot_accum #(
        .n   (TN),
        .LEN (TLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] s, input logic [63:0] c);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Present one beat and hold it until the DUT accepts it (bounded).
    task automatic beat(input logic [31:0] p, input logic last);
        bit took;
        int g;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        took     = 1'b0;
        g        = 0;
        while (!took && g < 20) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        if (!took) check("beat_accept_timeout", 64'(took), 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    // Result monitor: a handshake seen at the falling edge completes on the
    // next rising edge; compare against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("result sum=0x%0h count=%0d (expected sum=0x%0h count=%0d)",
                         out_sum, out_count, e.sum, e.cnt);
                check("out_sum", 64'(out_sum), e.sum);
                check("out_count", 64'(out_count), e.cnt);
            end
        end
    end

    initial begin
        int g;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1,2,3,4 back-to-back
        push_exp(64'd10, 64'd4);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        check("no_valid_before_len", 64'(out_valid), 64'd0);
        beat(32'd4, 1'b0);
        check("valid_after_len", 64'(out_valid), 64'd1);
        idle();
        @(posedge clk);
        #1;
        check("back_to_idle", 64'(out_valid), 64'd0);

        // Maximal products, guard bits absorb the carry
        push_exp(64'h3_FFF8_0004, 64'd4);
        repeat (4) beat(32'hFFFE_0001, 1'b0);
        idle();

        // Short vector terminated by in_last
        push_exp(64'd12, 64'd2);
        beat(32'd5, 1'b0);
        beat(32'd7, 1'b1);
        idle();
        @(posedge clk);
        #1;

        // Back-pressure, then handshake + accept on the same cycle
        out_ready = 1'b0;
        push_exp(64'd5, 64'd2);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b1);
        in_valid = 1'b1;
        in_prod  = 32'h0000_AAAA;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_sum", 64'(out_sum), 64'd5);
            check("hold_out_count", 64'(out_count), 64'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_prod   = 32'd9;
        in_last   = 1'b0;
        @(posedge clk);
        #1;
        check("restart_state", 64'(dut.state_reg), 64'(ACCUM));
        check("restart_acc", 64'(dut.acc_reg), 64'd9);
        check("restart_cnt", 64'(dut.cnt_reg), 64'd1);
        push_exp(64'd12, 64'd4);
        repeat (3) beat(32'd1, 1'b0);
        idle();
        @(posedge clk);
        #1;

        // Reset in the middle of a vector
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_count", 64'(out_count), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(64'd4, 64'd4);
        repeat (4) beat(32'd1, 1'b0);
        idle();

        // Single beat with in_last from IDLE
        @(posedge clk);
        #1;
        push_exp(64'd3, 64'd1);
        beat(32'h0000_0003, 1'b1);
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_count", 64'(out_count), 64'd1);
        idle();

        // Back-to-back vectors across HOLD, in_last on the LEN-th beat
        push_exp(64'd2, 64'd2);
        push_exp(64'd10, 64'd4);
        push_exp(64'd5, 64'd1);
        beat(32'd1, 1'b0);
        beat(32'd1, 1'b1);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd4, 1'b1);
        beat(32'd5, 1'b1);
        idle();

        g = 0;
        while (sb.size() != 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dot_accum

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 SHALL have parameter n, default 16, meaning the multiplier operand width; products are 2*n bits.
REQ-002 SHALL have parameter LEN, default 16, meaning the maximum number of products per dot product (LEN >= 1).
REQ-003 SHALL have derived localparam ACC_W = 2*n + clog2(LEN), meaning the accumulator width with guard bits; CNT_W = clog2(LEN+1).
REQ-004 SHALL have clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have in_valid  input  1  product beat present.
REQ-007 SHALL have in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have in_prod  input  2*n  unsigned product taken from the multiplier result port.
REQ-009 SHALL have in_last  input  1  marks the final beat of a vector when fewer than LEN beats are sent.
REQ-010 SHALL have out_valid  output  1  completed dot product available.
REQ-011 SHALL have out_ready  input  1  consumer takes the result.
REQ-012 SHALL have out_sum  output  ACC_W  unsigned sum of the vector's products.
REQ-013 SHALL have out_count  output  CNT_W  number of beats summed into out_sum.

Function
REQ-014 SHALL accept a beat only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL use a three-state FSM: IDLE, ACCUM and HOLD.
REQ-016 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-017 SHALL, on an accept in IDLE, load acc=in_prod and cnt=1, then go to HOLD if in_last or LEN==1, else to ACCUM.
REQ-018 SHALL, in ACCUM, drive in_ready=1; on an accept, set acc=acc+in_prod (zero-extended) and cnt=cnt+1.
REQ-019 SHALL, in ACCUM, go to HOLD when the accepted beat makes cnt==LEN or has in_last=1.
REQ-020 SHALL ignore in_last on a beat that already completes LEN beats.
REQ-021 SHALL, in HOLD, drive out_valid=1 with out_sum=acc and out_count=cnt, holding both stable until out_ready=1.
REQ-022 SHALL set out_valid exactly one cycle after the final beat is accepted; latency is 1 cycle.
REQ-023 SHALL, in HOLD, drive in_ready=out_ready.
REQ-024 SHALL, on a simultaneous output handshake and accept in HOLD, start a new vector with the IDLE-accept rules of REQ-017.
REQ-025 SHALL, on an output handshake in HOLD without an accept, return to IDLE.
REQ-026 SHALL never overflow; ACC_W guard bits cover LEN maximal products, and no saturation logic exists.
REQ-027 SHALL ignore in_prod and in_last whenever no accept occurs.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0 and out_count=0; in_ready SHALL read 1 after reset.
REQ-029 SHALL discard a partially accumulated vector on reset mid-operation; the next vector starts from zero.

Structure
REQ-030 SHALL take n, LEN, ACC_W, CNT_W and the state enum type from shared package mult_nn_pkg.
REQ-031 SHALL be a single module with no sub-modules; the multiplier is instantiated alongside it by the integrating top, not inside it.

Verification (n=16, LEN=4)
REQ-032 SHALL cover: beats 1,2,3,4 back-to-back with out_ready=1 -> out_valid=1 the cycle after beat 4, out_sum=10, out_count=4.
REQ-033 SHALL cover: four beats of 0xFFFE0001 -> out_sum=0x3FFF80004 (34 bits), no overflow.
REQ-034 SHALL cover: beats 5 then 7 with in_last=1 on 7 -> out_sum=12, out_count=2.
REQ-035 SHALL cover: result pending with out_ready=0 for 3 cycles -> in_ready=0 and out_sum stable; then out_ready=1 with in_valid=1, in_prod=9 -> handshake and accept in the same cycle, state=ACCUM, acc=9, cnt=1.
REQ-036 SHALL cover: rst_n pulsed low after 2 of 4 beats -> out_valid=0 immediately; then beats 1,1,1,1 -> out_sum=4.
REQ-037 SHALL cover: single beat 0x00000003 with in_last=1 from IDLE -> out_sum=3, out_count=1, one cycle later.
